// File: rtl/dm_load_unit_pkg.sv
// Shared wordmode codes, load FSM state encoding and the alignment helper
// for the MEM-stage load unit.
package dm_load_unit_pkg;

    // Wordmode codes, shared with the store-side byte-enable decoder.
    localparam logic [2:0] wm_wd = 3'd0;
    localparam logic [2:0] wm_hu = 3'd1;
    localparam logic [2:0] wm_hs = 3'd2;
    localparam logic [2:0] wm_bu = 3'd3;
    localparam logic [2:0] wm_bs = 3'd4;

    // Load FSM states.
    typedef enum logic [1:0] {
        ld_idle = 2'd0,
        ld_wait = 2'd1,
        ld_done = 2'd2
    } ld_state_t;

    // Word loads need addr[1:0]==0 and halfword loads need addr[0]==0.
    // Byte loads, including the unused codes that decode as bytes, never trap.
    function automatic logic is_misaligned(input logic [2:0] wm, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (wm == wm_wd)
            mis = (lo != 2'b00);
        else if ((wm == wm_hu) || (wm == wm_hs))
            mis = lo[0];
        return mis;
    endfunction

endpackage

// File: rtl/dm_load_unit_load_ext.sv
// Combinational extraction of the addressed byte, halfword or word from a
// bus read word, followed by sign or zero extension.
module load_ext
    import dm_load_unit_pkg::*;
(
    input  logic [2:0]  wordmode,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = addr[1] ? word[31:16] : word[15:0];
    assign w_byte = word[8*addr +: 8];

    // Pick the field for the wordmode; codes 5-7 fall through to byte-unsigned.
    always_comb begin
        data = word;
        case (wordmode)
            wm_wd:   data = word;
            wm_hu:   data = {16'h0000, w_half};
            wm_hs:   data = {{16{w_half[15]}}, w_half};
            wm_bs:   data = {{24{w_byte[7]}}, w_byte};
            default: data = {24'h000000, w_byte};
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// MEM-stage load unit: checks alignment, issues one word-aligned bus read
// with a request/ready handshake, extracts and extends the result, and
// stalls the pipeline until the access completes, times out or is flushed.
//
// Handshake: mem_req is held high for every cycle in WAIT; a read completes
// in the first WAIT cycle where mem_ready=1 (and flush=0), and mem_rdata is
// only looked at in that cycle. Dropping mem_req abandons the request.
module dm_load_unit
    import dm_load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  wordmode,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        buserr,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    ld_state_t   r_state;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [2:0]  r_wm;
    logic [1:0]  r_lo;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_adel;
    logic        r_buserr;

    logic        w_misaligned;
    logic [31:0] w_ext;

    assign w_misaligned = is_misaligned(wordmode, addr[1:0]);

    // Extraction always uses the latched access, never the live inputs.
    load_ext u_load_ext (
        .wordmode (r_wm),
        .addr     (r_lo),
        .word     (mem_rdata),
        .data     (w_ext)
    );

    // Load FSM with registered request, result and one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ld_idle;
            r_cnt      <= 8'd0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_wm       <= wm_wd;
            r_lo       <= 2'b00;
            r_rdata    <= 32'h0;
            r_done     <= 1'b0;
            r_adel     <= 1'b0;
            r_buserr   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_adel   <= 1'b0;
            r_buserr <= 1'b0;
            case (r_state)
                ld_idle: begin
                    if (start) begin
                        if (w_misaligned) begin
                            r_adel <= 1'b1;
                        end else begin
                            r_mem_addr <= {addr[31:2], 2'b00};
                            r_wm       <= wordmode;
                            r_lo       <= addr[1:0];
                            r_cnt      <= 8'd0;
                            r_mem_req  <= 1'b1;
                            r_state    <= ld_wait;
                        end
                    end
                end
                ld_wait: begin
                    // flush beats a simultaneous mem_ready: nothing commits.
                    if (flush) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ld_idle;
                    end else if (mem_ready) begin
                        r_rdata   <= w_ext;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ld_done;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_mem_req <= 1'b0;
                        r_buserr  <= 1'b1;
                        r_state   <= ld_idle;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ld_done: begin
                    // Result already committed; flush is ignored here.
                    r_state <= ld_idle;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= ld_idle;
                end
            endcase
        end
    end

    // Stall in the same cycle an aligned start is seen, and throughout WAIT.
    always_comb begin
        busy = ((r_state == ld_idle) && start && !w_misaligned) || (r_state == ld_wait);
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign rdata     = r_rdata;
    assign done      = r_done;
    assign adel      = r_adel;
    assign buserr    = r_buserr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit with hand-computed expected values.
module tb_dm_load_unit;
  import dm_load_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [2:0]  wordmode;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        buserr;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_errors;
  logic [31:0] last_rdata;

  dm_load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .wordmode  (wordmode),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .adel      (adel),
    .buserr    (buserr),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Aligned load: start at cycle 0, `waits` idle bus cycles, then mem_ready.
  // A stray start is held during the wait cycles and must be ignored.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] wm,
                          input int waits, input logic [31:0] word, input logic [31:0] exp);
    tick();
    start = 1'b1; addr = a; wordmode = wm; mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_c0_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_c0_req"}, {31'b0, mem_req}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      start = 1'b1; addr = 32'hFFFF_FFF0; wordmode = wm_bs;
      @(negedge clk);
      chk({tag, "_wait_req"}, {31'b0, mem_req}, 32'd1);
      chk({tag, "_wait_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, "_wait_done"}, {31'b0, done}, 32'd0);
    end
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = word;
    @(negedge clk);
    chk({tag, "_rdy_req"}, {31'b0, mem_req}, 32'd1);
    chk({tag, "_rdy_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_rdy_addr"}, mem_addr, {a[31:2], 2'b00});
    tick();
    mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done_req"}, {31'b0, mem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_done_off"}, {31'b0, done}, 32'd0);
    chk({tag, "_rdata_hold"}, rdata, exp);
    last_rdata = exp;
  endtask

  // Misaligned load: no request, no stall, adel one cycle later.
  task automatic run_adel(input string tag, input logic [31:0] a, input logic [2:0] wm);
    tick();
    start = 1'b1; addr = a; wordmode = wm;
    @(negedge clk);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_adel"}, {31'b0, adel}, 32'd1);
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk({tag, "_adel_off"}, {31'b0, adel}, 32'd0);
    chk({tag, "_req2"}, {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; last_rdata = 32'h0;
    reset = 1'b1; start = 1'b0; addr = 32'h0; wordmode = wm_wd;
    flush = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    tick();
    reset = 1'b0;

    run_load("lw", 32'h0000_1004, wm_wd, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb3", 32'h0000_2003, wm_bs, 0, 32'h80FF_7F01, 32'hFFFF_FF80);
    run_load("lbu3", 32'h0000_2003, wm_bu, 1, 32'h80FF_7F01, 32'h0000_0080);
    run_load("lh2", 32'h0000_2002, wm_hs, 0, 32'h80FF_7F01, 32'hFFFF_80FF);
    run_load("lhu2", 32'h0000_2002, wm_hu, 2, 32'h80FF_7F01, 32'h0000_80FF);
    run_load("lb1", 32'h0000_2001, wm_bs, 0, 32'h80FF_7F01, 32'h0000_007F);
    run_load("lbu0", 32'h0000_2000, wm_bu, 0, 32'h80FF_7F01, 32'h0000_0001);
    run_load("lh0", 32'h0000_2000, wm_hs, 0, 32'h80FF_7F01, 32'h0000_7F01);
    run_load("wm6", 32'h0000_2002, 3'd6, 0, 32'h80FF_7F01, 32'h0000_00FF);

    run_adel("adel_lw", 32'h0000_3002, wm_wd);
    run_adel("adel_lh", 32'h0000_3001, wm_hs);

    // Timeout with TIMEOUT_CYCLES=4: mem_req cycles 1-4, buserr at cycle 5.
    tick();
    start = 1'b1; addr = 32'h0000_4000; wordmode = wm_wd;
    @(negedge clk);
    chk("to_c0_busy", {31'b0, busy}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("to_req", {31'b0, mem_req}, 32'd1);
      chk("to_buserr_early", {31'b0, buserr}, 32'd0);
    end
    tick();
    @(negedge clk);
    chk("to_buserr", {31'b0, buserr}, 32'd1);
    chk("to_req_off", {31'b0, mem_req}, 32'd0);
    chk("to_no_done", {31'b0, done}, 32'd0);
    chk("to_busy_off", {31'b0, busy}, 32'd0);
    tick();
    @(negedge clk);
    chk("to_buserr_off", {31'b0, buserr}, 32'd0);

    // flush together with mem_ready: flush wins, rdata untouched.
    tick();
    start = 1'b1; addr = 32'h0000_5000; wordmode = wm_wd;
    tick();
    start = 1'b0; flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    flush = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("fl_req", {31'b0, mem_req}, 32'd0);
    chk("fl_done", {31'b0, done}, 32'd0);
    chk("fl_rdata", rdata, last_rdata);
    chk("fl_buserr", {31'b0, buserr}, 32'd0);
    tick();
    @(negedge clk);
    chk("fl_done2", {31'b0, done}, 32'd0);
    chk("fl_state", {30'b0, dbg_state}, 32'd0);

    // Asynchronous reset while in WAIT.
    tick();
    start = 1'b1; addr = 32'h0000_6008; wordmode = wm_wd;
    tick();
    start = 1'b0;
    #2;
    chk("ar_pre_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_req", {31'b0, mem_req}, 32'd0);
    chk("ar_maddr", mem_addr, 32'h0);
    chk("ar_rdata", rdata, 32'h0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_state", {30'b0, dbg_state}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ar_done", {31'b0, done}, 32'd0);
    chk("ar_buserr", {31'b0, buserr}, 32'd0);
    run_load("after_rst", 32'h0000_700C, wm_wd, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_load_unit.md
# dm_load_unit

Load-side data-memory access unit for the MIPS pipeline's MEM stage. It is the read counterpart of the store byte-enable decoder. It issues a word-aligned read on the data bus with a request/ready handshake and checks load alignment. It extracts the byte, halfword or word selected by `wordmode` and `addr[1:0]`, sign- or zero-extends it, and stalls the pipeline until the access completes, times out, or is flushed.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in WAIT before a bus error is raised (range 1–255).

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  MEM-stage load valid; sampled only in IDLE
- `addr`  in  32  byte address of the load
- `wordmode`  in  3  `wm_wd`/`wm_hu`/`wm_hs`/`wm_bu`/`wm_bs`
- `flush`  in  1  kills any in-flight access (exception or interrupt)
- `mem_req`  out  1  read request to the bus
- `mem_addr`  out  32  `{addr[31:2],2'b00}` of the latched access
- `mem_ready`  in  1  bus read data valid this cycle
- `mem_rdata`  in  32  bus read word
- `busy`  out  1  pipeline stall
- `done`  out  1  one-cycle pulse; `rdata` is valid
- `rdata`  out  32  extended load result
- `adel`  out  1  one-cycle pulse on a misaligned load
- `buserr`  out  1  one-cycle pulse on a timeout

## Operation
- States: IDLE, WAIT, DONE.
- IDLE with `start`=1:
  - Misaligned access goes to IDLE, with `adel`=1 in the next cycle and no request issued. Misaligned means `wm_wd` with `addr[1:0]`≠0, or `wm_hu`/`wm_hs` with `addr[0]`=1.
  - Otherwise latch `addr` and `wordmode`, clear the counter, and go to WAIT.
- IDLE with `start`=0: stay in IDLE.
- WAIT: `mem_req`=1 and `mem_addr` is driven from the latched address.
  - `flush`=1 goes to IDLE; no `done`, no `buserr`. If `flush` and `mem_ready` arrive together, `flush` wins.
  - Otherwise, `mem_ready`=1 captures the extracted result into `rdata` and goes to DONE.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1, go to IDLE with `buserr`=1 in the next cycle.
  - Otherwise, increment the counter.
- DONE: `done`=1 for exactly one cycle, then IDLE. `flush` in DONE has no effect; the result is already committed.
- `start` outside IDLE is ignored.
- Extraction from `mem_rdata`, using the latched `addr`:
  - `wm_wd`: the whole word.
  - `wm_hu`/`wm_hs`: half `[15:0]` when `addr[1]`=0, `[31:16]` when `addr[1]`=1.
  - `wm_bu`/`wm_bs`: byte `addr[1:0]`, i.e. `[8k+7:8k]`.
- Extension: `hs`/`bs` sign-extend from the MSB of the selected field; `hu`/`bu` zero-extend.
- Unused wordmode codes 5–7 are treated as `wm_bu`, matching the store side's default-to-byte decoding.
- `rdata` holds its value until the next capture.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `mem_req`, `done`, `adel`, `buserr` = 0.
  - `rdata`, `mem_addr` = 0.
- Reset asserted mid-access returns to IDLE immediately, drops `mem_req`, and produces no pulses.
- `busy` = (IDLE & `start` & aligned) | WAIT. This is combinational, so the pipeline stalls in the same cycle `start` is seen.
- Latency with `start` at cycle 0:
  - `mem_req` is high from cycle 1.
  - If `mem_ready` is first high at cycle k ≥ 1, `done` and the new `rdata` appear at cycle k+1.
  - `busy` is high from cycle 0 through cycle k.
- A zero-wait bus (`mem_ready` at cycle 1) gives `done` at cycle 2.
- A timeout drops `mem_req` after `TIMEOUT_CYCLES` WAIT cycles; `buserr` pulses in the following cycle.
- `adel` pulses at cycle 1 and `busy` is 0 at cycle 0.
- `mem_req` is a registered output: it is high exactly while the state is WAIT.

## Structure
- Wordmode codes go in `head.v` alongside the existing store-side definitions: `wm_wd`=0, `wm_hu`=1, `wm_hs`=2, `wm_bu`=3, `wm_bs`=4.
- State encodings go in `head.v`: `ld_idle`, `ld_wait`, `ld_done`.
- Sub-module `load_ext`: purely combinational extraction and extension, with inputs `wordmode`, `addr[1:0]`, `word` and output `data`. It is instantiated once, on `mem_rdata`.

## Test plan
- Aligned `lw` from 0x0000_1004, `mem_ready` at cycle 1 with 0xDEADBEEF:
  - `mem_addr`=0x0000_1004.
  - `done` and `rdata`=0xDEADBEEF at cycle 2; `busy` high for cycles 0–1.
- `lb`/`lbu` at `addr[1:0]`=3, `lh`/`lhu` at `addr[1]`=1, with word 0x80FF_7F01:
  - `lb` → 0xFFFF_FF80, `lbu` → 0x0000_0080.
  - `lh` → 0xFFFF_80FF, `lhu` → 0x0000_80FF.
- `lw` at 0x...02 and `lh` at 0x...01:
  - `adel` pulses at cycle 1.
  - `mem_req` never asserts and `busy`=0.
- `mem_ready` held low with `TIMEOUT_CYCLES`=4:
  - `mem_req` high for cycles 1–4.
  - `buserr` at cycle 5, and no `done`.
- `flush` and `mem_ready` in the same WAIT cycle:
  - Return to IDLE; `rdata` is unchanged and no `done`.
- `reset` asserted in WAIT:
  - All outputs go to 0 asynchronously.
  - A new `start` after release completes normally.
